// File: rtl/stream_pass_sequencer.sv
// Multi-pass controller for the padded BRAM streamer: per pass it clears, launches, waits, drains, commits.
// Optional macro PASS_PERF_CNT_EN adds the perf_cycles / perf_stall counters.
module stream_pass_sequencer #(
    parameter int PASS_W    = 5,
    parameter int ADDR_W    = 9,
    parameter int DRAIN_CYC = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_go,
    input  logic [PASS_W-1:0] cfg_num_passes,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_pass_stride,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [PASS_W-1:0] pass_idx,
    output logic              strm_start,
    output logic [ADDR_W-1:0] strm_base_addr,
    input  logic              strm_busy,
    input  logic              strm_done,
    input  logic              pipe_idle,
    output logic              acc_clear,
    output logic              acc_commit
`ifdef PASS_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_COMMIT, S_FINISH
    } state_t;

    localparam int DC_W = $clog2(DRAIN_CYC + 1);

    state_t               state_q, state_d;
    logic [PASS_W-1:0]    num_q, num_d, pass_q, pass_d;
    logic [ADDR_W-1:0]    stride_q, stride_d, base_q, base_d;
    logic                 err_q, err_d, zdone_q, zdone_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d, wdog_inc;
    logic [DC_W-1:0]      dcnt_q, dcnt_d;
    logic                 go_accept;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            stride_q <= '0;
            pass_q   <= '0;
            base_q   <= '0;
            err_q    <= 1'b0;
            zdone_q  <= 1'b0;
            wdog_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            stride_q <= stride_d;
            pass_q   <= pass_d;
            base_q   <= base_d;
            err_q    <= err_d;
            zdone_q  <= zdone_d;
            wdog_q   <= wdog_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign pass_idx       = pass_q;
    assign strm_base_addr = base_q;
    assign error          = err_q;
    assign wdog_inc       = wdog_q + 1'b1;
    assign go_accept      = (state_q == S_IDLE) && cfg_go && (cfg_num_passes != '0);

    // NOTE: every signal gets a default before the case statement so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        stride_d   = stride_q;
        pass_d     = pass_q;
        base_d     = base_q;
        err_d      = err_q;
        zdone_d    = 1'b0;
        wdog_d     = wdog_q;
        dcnt_d     = dcnt_q;
        busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
        done       = zdone_q;
        strm_start = 1'b0;
        acc_clear  = 1'b0;
        acc_commit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go_accept) begin
                    num_d    = cfg_num_passes;
                    stride_d = cfg_pass_stride;
                    base_d   = cfg_base_addr;
                    pass_d   = '0;
                    err_d    = 1'b0;
                    state_d  = S_LAUNCH;
                end else if (cfg_go) begin
                    zdone_d = 1'b1;
                end
            end
            S_LAUNCH: begin
                acc_clear = 1'b1;
                wdog_d    = '0;
                if (!strm_busy) begin
                    strm_start = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                // A done arriving on the final watchdog cycle still counts as a completed pass.
                if (strm_done) begin
                    dcnt_d  = DC_W'(DRAIN_CYC - 1);
                    state_d = S_DRAIN;
                end else if (wdog_inc == '1) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            S_DRAIN: begin
                if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - 1'b1;
                end else if (pipe_idle) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                acc_commit = 1'b1;
                if (pass_q == num_q - 1'b1) begin
                    state_d = S_FINISH;
                end else begin
                    pass_d  = pass_q + 1'b1;
                    base_d  = base_q + stride_q;
                    state_d = S_LAUNCH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including pulses the current state would have produced.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            pass_d     = pass_q;
            base_d     = base_q;
            err_d      = err_q;
            done       = 1'b0;
            strm_start = 1'b0;
            acc_clear  = 1'b0;
            acc_commit = 1'b0;
        end
    end

`ifdef PASS_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || go_accept) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if ((state_q == S_DRAIN) && !pipe_idle && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_pass_sequencer.sv
// Self-checking bench for stream_pass_sequencer: a timeline model paints expected outputs per cycle,
// one compare process checks them every cycle, and literal checks pin key latencies and addresses.
module tb_stream_pass_sequencer;

    localparam int PW = 5;
    localparam int AW = 9;
    localparam int DC = 4;
    localparam int TW = 8;
    localparam int N  = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_go = 1'b0;
    logic [PW-1:0] cfg_num_passes = '0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [AW-1:0] cfg_pass_stride = '0;
    logic          abort = 1'b0;
    logic          strm_busy = 1'b0;
    logic          strm_done = 1'b0;
    logic          pipe_idle = 1'b1;
    logic          busy, done, error, strm_start, acc_clear, acc_commit;
    logic [PW-1:0] pass_idx;
    logic [AW-1:0] strm_base_addr;

    always #5 clk = ~clk;

    stream_pass_sequencer #(
        .PASS_W(PW), .ADDR_W(AW), .DRAIN_CYC(DC), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_go(cfg_go), .cfg_num_passes(cfg_num_passes),
        .cfg_base_addr(cfg_base_addr), .cfg_pass_stride(cfg_pass_stride), .abort(abort),
        .busy(busy), .done(done), .error(error), .pass_idx(pass_idx), .strm_start(strm_start),
        .strm_base_addr(strm_base_addr), .strm_busy(strm_busy), .strm_done(strm_done),
        .pipe_idle(pipe_idle), .acc_clear(acc_clear), .acc_commit(acc_commit)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output timeline, indexed by cycle (cycle c = interval after the c-th rising edge).
    bit e_busy[N], e_done[N], e_err[N], e_clear[N], e_start[N], e_commit[N];
    int e_pidx[N], e_base[N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            check("busy", busy, e_busy[cyc]);
            check("done", done, e_done[cyc]);
            check("error", error, e_err[cyc]);
            check("acc_clear", acc_clear, e_clear[cyc]);
            check("strm_start", strm_start, e_start[cyc]);
            check("acc_commit", acc_commit, e_commit[cyc]);
            if (e_busy[cyc]) begin
                check("pass_idx", pass_idx, e_pidx[cyc]);
                check("strm_base_addr", strm_base_addr, e_base[cyc]);
            end
        end
    end

    // Observed event log used by the literal checks.
    int n_start = 0, n_commit = 0, n_done = 0, n_clear = 0;
    int last_done = 0, last_commit = 0, err_rise = 0, start_cyc_last = 0;
    logic err_prev = 1'b0;
    logic [AW-1:0] start_addr_q[$];
    logic [PW-1:0] commit_idx_q[$];

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (strm_start === 1'b1) begin
                n_start++;
                start_cyc_last = cyc;
                start_addr_q.push_back(strm_base_addr);
            end
            if (acc_clear === 1'b1) n_clear++;
            if (acc_commit === 1'b1) begin
                n_commit++;
                last_commit = cyc;
                commit_idx_q.push_back(pass_idx);
            end
            if (done === 1'b1) begin
                n_done++;
                last_done = cyc;
            end
            if (error === 1'b1 && err_prev !== 1'b1) err_rise = cyc;
            err_prev = error;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Paints one pass: launch at t (held h extra cycles), strm_done run_len cycles after the
    // start pulse, drain of DC cycles plus stall, then commit. Painting stops at abort cycle ab.
    function automatic int paint_pass(int t, int h, int run_len, int stall, int p, int addr, int ab);
        int sd, c, last;
        sd   = t + h + run_len;
        c    = sd + DC + 1 + stall;
        last = (ab >= 0 && ab < c) ? ab : c;
        for (int k = t; k <= last; k++) begin
            e_busy[k]   = 1'b1;
            e_pidx[k]   = p;
            e_base[k]   = addr;
            e_clear[k]  = (k <= t + h) && (k != ab);
            e_start[k]  = (k == t + h) && (k != ab);
            e_commit[k] = (k == c) && (k != ab);
        end
        return c;
    endfunction

    task automatic scramble_cfg();
        cfg_num_passes  = PW'($urandom);
        cfg_base_addr   = AW'($urandom);
        cfg_pass_stride = AW'($urandom);
    endtask

    int last_sd = 0;

    task automatic job(input int num, input int base, input int stride, input int run_len,
                       input int stall, input int h, input int abort_pass, input int abort_ofs);
        int g, t, sd, c, addr, a, hh;
        bit aborted;
        aborted = 1'b0;
        g = cyc;
        cfg_go = 1'b1;
        cfg_num_passes = PW'(num);
        cfg_base_addr = AW'(base);
        cfg_pass_stride = AW'(stride);
        if (num == 0) begin
            e_done[g + 1] = 1'b1;
            tick();
            cfg_go = 1'b0;
            scramble_cfg();
            repeat (3) tick();
            return;
        end
        for (int k = g + 1; k < N; k++) e_err[k] = 1'b0;
        t = g + 1;
        for (int p = 0; p < num; p++) begin
            hh   = (p == 0) ? h : 0;
            addr = (base + p * stride) % (1 << AW);
            sd   = t + hh + run_len;
            a    = (p == abort_pass) ? sd + abort_ofs : -1;
            c    = paint_pass(t, hh, run_len, stall, p, addr, a);
            if (a < 0 && p == num - 1) e_done[c + 1] = 1'b1;
            last_sd = sd;
            if (p == 0) begin
                tick();
                cfg_go = 1'b0;
                scramble_cfg();
                if (hh > 0) begin
                    strm_busy = 1'b1;
                    while (cyc < t + hh) tick();
                    strm_busy = 1'b0;
                end
            end
            // A go (with zero passes) while busy must be ignored.
            while (cyc < t + hh + 1) tick();
            cfg_go = 1'b1;
            cfg_num_passes = '0;
            tick();
            cfg_go = 1'b0;
            while (cyc < sd) tick();
            strm_done = 1'b1;
            if (a == sd) abort = 1'b1;
            tick();
            strm_done = 1'b0;
            if (a == sd) begin
                abort = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (stall > 0) begin
                pipe_idle = 1'b0;
                while (cyc < sd + DC + stall) tick();
                pipe_idle = 1'b1;
            end
            if (a >= 0) begin
                while (cyc < a) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                aborted = 1'b1;
                break;
            end
            while (cyc <= c) tick();
            t = c + 1;
        end
        if (aborted) begin
            repeat (3) tick();
            strm_done = 1'b1;
            tick();
            strm_done = 1'b0;
            repeat (3) tick();
        end else begin
            tick();
        end
    endtask

    task automatic watchdog_job(input int base);
        int g, t;
        g = cyc;
        t = g + 1;
        cfg_go = 1'b1;
        cfg_num_passes = PW'(1);
        cfg_base_addr = AW'(base);
        cfg_pass_stride = '0;
        void'(paint_pass(t, 0, 100000, 0, 0, base, t + (1 << TW) - 1));
        for (int k = t; k < N; k++) e_err[k] = (k >= t + (1 << TW));
        tick();
        cfg_go = 1'b0;
        scramble_cfg();
        while (cyc < t + (1 << TW) + 4) tick();
    endtask

    task automatic do_reset();
        int r;
        r = cyc;
        for (int k = r + 1; k < N; k++) e_err[k] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic reset_mid_run();
        int g, t;
        g = cyc;
        t = g + 1;
        cfg_go = 1'b1;
        cfg_num_passes = PW'(2);
        cfg_base_addr = AW'('h0A0);
        cfg_pass_stride = AW'('h011);
        for (int k = t; k < N; k++) e_err[k] = 1'b0;
        void'(paint_pass(t, 0, 50, 0, 0, 'h0A0, t + 20));
        tick();
        cfg_go = 1'b0;
        while (cyc < t + 20) tick();
        do_reset();
    endtask

    int s_start, s_commit, s_done, s_clear;

    task automatic snap();
        s_start = n_start;
        s_commit = n_commit;
        s_done = n_done;
        s_clear = n_clear;
        start_addr_q.delete();
        commit_idx_q.delete();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single pass, 200-cycle streamer run.
        snap();
        job(1, 'h010, 'h0C4, 200, 0, 0, -1, 0);
        check("sp_starts", n_start - s_start, 1);
        check("sp_clears", n_clear - s_clear, 1);
        check("sp_commits", n_commit - s_commit, 1);
        check("sp_addr", start_addr_q.size() > 0 ? start_addr_q[0] : 'x, 'h010);
        check("sp_done_latency", last_done - last_sd, 6);

        // Three passes with address wrap.
        snap();
        job(3, 'h1F0, 'h0C4, 12, 0, 0, -1, 0);
        check("mp_addr0", start_addr_q.size() > 0 ? start_addr_q[0] : 'x, 'h1F0);
        check("mp_addr1", start_addr_q.size() > 1 ? start_addr_q[1] : 'x, 'h0B4);
        check("mp_addr2", start_addr_q.size() > 2 ? start_addr_q[2] : 'x, 'h178);
        check("mp_idx2", commit_idx_q.size() > 2 ? commit_idx_q[2] : 'x, 2);
        check("mp_commits", n_commit - s_commit, 3);
        check("mp_dones", n_done - s_done, 1);

        // Drain backpressure of 10 cycles, with the streamer busy for 3 cycles at launch.
        snap();
        job(2, 'h020, 'h004, 20, 10, 3, -1, 0);
        check("bp_commit_latency", last_commit - last_sd, 15);
        check("bp_clears", n_clear - s_clear, 5);

        // Zero passes.
        snap();
        job(0, 'h030, 'h001, 0, 0, 0, -1, 0);
        check("zp_starts", n_start - s_start, 0);
        check("zp_dones", n_done - s_done, 1);

        // Watchdog, then a new go clears the error.
        snap();
        watchdog_job('h033);
        check("wd_latency", err_rise - start_cyc_last, 256);
        check("wd_dones", n_done - s_done, 0);
        job(1, 'h040, 'h010, 5, 0, 0, -1, 0);
        check("wd_recover_err", error, 0);
        check("wd_recover_done", n_done - s_done, 1);

        // Watchdog, then reset in IDLE clears the error.
        watchdog_job('h055);
        do_reset();
        check("rst_err_clear", error, 0);

        // Reset mid-RUN.
        reset_mid_run();

        // Abort coincident with strm_done, then a stray strm_done in IDLE.
        snap();
        job(2, 'h100, 'h020, 10, 0, 0, 0, 0);
        check("ab_commits", n_commit - s_commit, 0);
        check("ab_dones", n_done - s_done, 0);

        // Abort in the final COMMIT cycle.
        snap();
        job(2, 'h100, 'h020, 6, 0, 0, 1, DC + 1);
        check("abc_commits", n_commit - s_commit, 1);
        check("abc_dones", n_done - s_done, 0);

        check("cycle_budget", 32'(cyc < N), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(N * 10 + 500);
        $display("FAIL timeout: simulation did not finish within %0d cycles", N);
        $fatal(1);
    end

endmodule
